// File: rtl/fetch_queue.sv
// Instruction-fetch front end: single-outstanding word reads into a small {pc, instr} FIFO.
// Define FETCH_BYPASS_EN to let a word returning into an empty queue reach IF in the same cycle.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        deq,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [31:0]      q_pc    [DEPTH];
  logic [31:0]      q_instr [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      fetch_pc;
  logic [31:0]      req_pc;
  logic             outstanding;
  logic             discard;

  logic             accept;
  logic             resp;
  logic             bypass_hit;
  logic             push;
  logic             pop;
  logic             pending_next;
  logic             outstanding_next;
  logic             discard_next;
  logic             mem_req_next;
  logic [31:0]      mem_addr_next;
  logic [31:0]      fetch_pc_next;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    accept     = mem_req & mem_ready;
    resp       = mem_rvalid & outstanding;
    bypass_hit = 1'b0;
`ifdef FETCH_BYPASS_EN
    bypass_hit = resp & ~discard & ~redirect & (count == '0);
`endif
    push = resp & ~discard & ~redirect & ~(bypass_hit & deq);
    pop  = deq & (count != '0) & ~redirect;

    count_next = count;
    if (redirect) begin
      count_next = '0;
    end else if (push & ~pop) begin
      count_next = count + CNT_W'(1);
    end else if (pop & ~push) begin
      count_next = count - CNT_W'(1);
    end

    // A request still pending from before a redirect is stale and must not advance the PC.
    fetch_pc_next = fetch_pc;
    if (redirect) begin
      fetch_pc_next = {redirect_pc[31:2], 2'b00};
    end else if (accept & ~discard) begin
      fetch_pc_next = fetch_pc + 32'd4;
    end

    outstanding_next = accept | (outstanding & ~resp);
    pending_next     = mem_req & ~mem_ready;

    discard_next = discard;
    if (redirect) begin
      discard_next = (outstanding & ~mem_rvalid) | mem_req;
    end else if (resp & discard) begin
      discard_next = 1'b0;
    end

    mem_req_next  = pending_next | (~outstanding_next & (count_next < FULL));
    mem_addr_next = pending_next ? mem_addr : fetch_pc_next;
  end

  always_comb begin
    instr_valid = (count != '0) | bypass_hit;
    instr_out   = q_instr[rd_ptr];
    instr_pc    = q_pc[rd_ptr];
    if ((count == '0) && bypass_hit) begin
      instr_out = mem_rdata;
      instr_pc  = req_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_pc        <= '{default: '0};
      q_instr     <= '{default: '0};
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      fetch_pc    <= RESET_PC;
      req_pc      <= RESET_PC;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= RESET_PC;
    end else begin
      count       <= count_next;
      fetch_pc    <= fetch_pc_next;
      outstanding <= outstanding_next;
      discard     <= discard_next;
      mem_req     <= mem_req_next;
      mem_addr    <= mem_addr_next;
      if (accept) begin
        req_pc <= mem_addr;
      end
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          q_pc[wr_ptr]    <= req_pc;
          q_instr[wr_ptr] <= mem_rdata;
          wr_ptr          <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: memory model returns addr^FFFF_FFFF, scoreboard tracks queue contents.
module tb_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        deq;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  exp_t        exp_q[$];
  logic [31:0] exp_fetch_pc;
  bit          tb_outstanding;
  bit          tb_drop;
  bit          tb_stale;
  bit          prev_req_wait;
  logic [31:0] prev_addr;
  int          pops;
  logic [31:0] last_pop_pc;
  logic [31:0] last_pop_instr;

  bit          mem_pend;
  logic [31:0] mem_pend_addr;
  logic [31:0] resp_addr;
  int          mem_wait;
  int          lat;
  bit          ready_en;

  fetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .deq         (deq),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory side: one response per accepted request, lat cycles after acceptance.
  task automatic mem_drive();
    mem_rvalid = 1'b0;
    mem_ready  = ready_en;
    if (mem_pend) begin
      if (mem_wait <= 1) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_pend_addr ^ 32'hFFFF_FFFF;
        resp_addr  = mem_pend_addr;
        mem_pend   = 1'b0;
      end else begin
        mem_wait--;
      end
    end
  endtask

  // Scoreboard: evaluates one cycle with all inputs and outputs settled.
  task automatic score_cycle();
    bit   acc;
    bit   out_before;
    exp_t e;
    acc        = (mem_req === 1'b1) && (mem_ready === 1'b1);
    out_before = tb_outstanding;

    checks++;
    if (instr_valid !== (exp_q.size() != 0)) begin
      failures++;
      $display("[TB] FAIL sb_valid: instr_valid=%b expected=%b", instr_valid, exp_q.size() != 0);
    end else if (exp_q.size() != 0) begin
      checks++;
      if (instr_pc !== exp_q[0].pc || instr_out !== exp_q[0].instr) begin
        failures++;
        $display("[TB] FAIL sb_head: pc=%h instr=%h expected pc=%h instr=%h",
                 instr_pc, instr_out, exp_q[0].pc, exp_q[0].instr);
      end
    end
    if (out_before) begin
      checks++;
      if (mem_req !== 1'b0) begin
        failures++;
        $display("[TB] FAIL sb_req_outstanding: mem_req=%b expected=0", mem_req);
      end
    end
    if (prev_req_wait) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== prev_addr) begin
        failures++;
        $display("[TB] FAIL sb_hold: mem_req=%b mem_addr=%h expected 1 / %h", mem_req, mem_addr, prev_addr);
      end
    end
    if (acc) begin
      if (tb_stale) begin
        tb_stale = 1'b0;
      end else begin
        checks++;
        if (mem_addr !== exp_fetch_pc) begin
          failures++;
          $display("[TB] FAIL sb_addr: mem_addr=%h expected=%h", mem_addr, exp_fetch_pc);
        end
        exp_fetch_pc += 32'd4;
      end
      mem_pend      = 1'b1;
      mem_pend_addr = mem_addr;
      mem_wait      = lat;
    end
    if (deq && !redirect && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      pops++;
      last_pop_pc    = instr_pc;
      last_pop_instr = instr_out;
    end
    if (mem_rvalid && out_before) begin
      tb_outstanding = 1'b0;
      if (tb_drop) begin
        tb_drop = 1'b0;
      end else if (!redirect) begin
        e.pc    = resp_addr;
        e.instr = resp_addr ^ 32'hFFFF_FFFF;
        exp_q.push_back(e);
      end
    end
    if (acc) tb_outstanding = 1'b1;
    if (redirect) begin
      exp_q.delete();
      exp_fetch_pc = {redirect_pc[31:2], 2'b00};
      tb_drop      = (out_before && !mem_rvalid) || (mem_req === 1'b1);
      tb_stale     = (mem_req === 1'b1) && (mem_ready !== 1'b1);
    end
    prev_req_wait = (mem_req === 1'b1) && (mem_ready !== 1'b1);
    prev_addr     = mem_addr;
  endtask

  task automatic step();
    @(negedge clk);
    score_cycle();
    @(posedge clk);
    #1;
    mem_drive();
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_fetch_pc   = RESET_PC;
    tb_outstanding = 1'b0;
    tb_drop        = 1'b0;
    tb_stale       = 1'b0;
    prev_req_wait  = 1'b0;
    mem_pend       = 1'b0;
  endtask

  task automatic wait_pop(input string name, input int budget);
    int p0;
    p0 = pops;
    for (int i = 0; i < budget && pops == p0; i++) step();
    checks++;
    if (pops == p0) begin
      failures++;
      $display("[TB] FAIL %s_timeout: pops=%0d required>%0d", name, pops, p0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; deq = 1'b0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    lat = 1; ready_en = 1'b1; pops = 0;
    model_reset();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== RESET_PC || instr_valid !== 1'b0 ||
        instr_out !== 32'h0 || instr_pc !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_values: req=%b addr=%h valid=%b out=%h pc=%h required 0/%h/0/0/0",
               mem_req, mem_addr, instr_valid, instr_out, instr_pc, RESET_PC);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    mem_drive();
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== RESET_PC) begin
      failures++;
      $display("[TB] FAIL reset_first_req: req=%b addr=%h required 1/%h", mem_req, mem_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    int p0;
    deq = 1'b1;
    p0  = pops;
    for (int i = 0; i < 24; i++) step();
    checks++;
    if (pops - p0 < 10 || pops - p0 > 12) begin
      failures++;
      $display("[TB] FAIL stream_rate: pops=%0d required 10..12 in 24 cycles", pops - p0);
    end
  endtask

  task automatic test_stall();
    logic [31:0] head;
    deq = 1'b0;
    for (int i = 0; i < 20; i++) step();
    head = (exp_q.size() != 0) ? exp_q[0].pc : 32'hFFFF_FFFF;
    checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b1 || exp_q.size() != 4 || instr_pc !== head) begin
      failures++;
      $display("[TB] FAIL stall_full: req=%b valid=%b entries=%0d pc=%h required 0/1/4/%h",
               mem_req, instr_valid, exp_q.size(), instr_pc, head);
    end
    deq = 1'b1;
    for (int i = 0; i < 20 && mem_req !== 1'b1; i++) step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== head + 32'd16) begin
      failures++;
      $display("[TB] FAIL stall_resume: req=%b addr=%h required 1/%h", mem_req, mem_addr, head + 32'd16);
    end
    for (int i = 0; i < 8; i++) step();
  endtask

  task automatic test_redirect_outstanding();
    deq = 1'b1;
    lat = 3;
    for (int i = 0; i < 20 && !(tb_outstanding && !mem_rvalid); i++) step();
    checks++;
    if (!(tb_outstanding && !mem_rvalid)) begin
      failures++;
      $display("[TB] FAIL redir_out_setup: outstanding=%b required 1", tb_outstanding);
    end
    deq = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0; deq = 1'b1;
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL redir_out_empty: instr_valid=%b required 0", instr_valid);
    end
    wait_pop("redir_out", 40);
    checks++;
    if (last_pop_pc !== 32'h0000_0100) begin
      failures++;
      $display("[TB] FAIL redir_out_pc: instr_pc=%h required 00000100", last_pop_pc);
    end
  endtask

  task automatic test_redirect_idle();
    deq = 1'b0;
    lat = 1;
    for (int i = 0; i < 60 && !(mem_req === 1'b0 && !tb_outstanding && exp_q.size() == 4); i++) step();
    checks++;
    if (!(mem_req === 1'b0 && !tb_outstanding)) begin
      failures++;
      $display("[TB] FAIL redir_idle_setup: req=%b outstanding=%b required 0/0", mem_req, tb_outstanding);
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0202;
    step();
    redirect = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0200 || instr_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL redir_idle_req: req=%b addr=%h valid=%b required 1/00000200/0",
               mem_req, mem_addr, instr_valid);
    end
  endtask

  task automatic test_ready_hold();
    logic [31:0] held;
    ready_en  = 1'b0;
    mem_ready = 1'b0;
    held      = mem_addr;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== held) begin
        failures++;
        $display("[TB] FAIL hold_stable: cycle=%0d req=%b addr=%h required 1/%h", i, mem_req, mem_addr, held);
      end
      if (i == 2) begin
        redirect = 1'b1; redirect_pc = 32'h0000_0300;
      end
      step();
      redirect = 1'b0;
    end
    ready_en  = 1'b1;
    mem_ready = 1'b1;
    deq       = 1'b1;
    wait_pop("hold", 40);
    checks++;
    if (last_pop_pc !== 32'h0000_0300 || last_pop_instr !== ~32'h0000_0300) begin
      failures++;
      $display("[TB] FAIL hold_redirect_pc: pc=%h instr=%h required 00000300/%h",
               last_pop_pc, last_pop_instr, ~32'h0000_0300);
    end
  endtask

  task automatic test_back_to_back();
    redirect = 1'b1; redirect_pc = 32'h0000_0380;
    step();
    redirect = 1'b0;
    deq = 1'b0;
    for (int i = 0; i < 40 && !(exp_q.size() == 2 && mem_rvalid && tb_outstanding); i++) step();
    checks++;
    if (!(exp_q.size() == 2 && mem_rvalid && tb_outstanding)) begin
      failures++;
      $display("[TB] FAIL collide_setup: entries=%0d rvalid=%b required 2/1", exp_q.size(), mem_rvalid);
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0400; deq = 1'b1;
    step();
    redirect = 1'b0; deq = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h0000_0400) begin
      failures++;
      $display("[TB] FAIL collide_state: valid=%b req=%b addr=%h required 0/1/00000400",
               instr_valid, mem_req, mem_addr);
    end
    deq = 1'b1;
    wait_pop("collide", 20);
    checks++;
    if (last_pop_pc !== 32'h0000_0400) begin
      failures++;
      $display("[TB] FAIL collide_pc: instr_pc=%h required 00000400", last_pop_pc);
    end
  endtask

  task automatic test_reset_midflight();
    deq = 1'b1;
    lat = 3;
    for (int i = 0; i < 20 && !tb_outstanding; i++) step();
    reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== RESET_PC) begin
      failures++;
      $display("[TB] FAIL midreset_clear: req=%b valid=%b addr=%h required 0/0/%h",
               mem_req, instr_valid, mem_addr, RESET_PC);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    lat = 1; ready_en = 1'b1;
    reset = 1'b1;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    wait_pop("midreset", 20);
    checks++;
    if (last_pop_pc !== RESET_PC || last_pop_instr !== ~RESET_PC) begin
      failures++;
      $display("[TB] FAIL midreset_first: pc=%h instr=%h required %h/%h",
               last_pop_pc, last_pop_instr, RESET_PC, ~RESET_PC);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_outstanding();
    test_redirect_idle();
    test_ready_hold();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
